bpc_sng_et: RTL and testbench
=============================

// Module: bpc_sng_et
// PURPOSE
//  Multi-channel counter-based stochastic number generator with programmable early termination.
//  One TW-bit sample counter is split into S_GROUPS W-bit groups; each channel compares its group value to its own binary input.
//  Runs of 2^len samples are started by handshake. Per-channel ones counts are accumulated and returned with done.
//  Sits between the binary operand registers and the SC datapath; feeds early-termination experiments.
// PARAMETERS
//  W        4   bits per binary input / per counter group
//  S_GROUPS 2   number of counter groups; TW = S_GROUPS*W
//  N        2   number of SN output channels
//  GSW      1   group-select width, = max(1,$clog2(S_GROUPS))
//  LW       4   len width, >= $clog2(TW+1)
// PORTS
//  clk       in   1          clock, rising edge
//  rst_n     in   1          asynchronous active-low reset
//  start     in   1          request run; accepted only in IDLE
//  abort     in   1          synchronous abort of a run
//  en        in   1          sample enable; 0 stalls the run
//  len       in   LW         log2 run length, latched on start
//  Bxs       in   W x N      per-channel binary input, latched on start
//  sel       in   GSW x N    per-channel counter group, latched on start
//  rev       in   N          per-channel bit-reverse of group value, latched on start
//  busy      out  1          high in RUN
//  xs        out  N          SN bits, registered
//  xs_valid  out  1          xs holds a new sample this cycle
//  done      out  1          one-cycle pulse: run completed
//  ones      out  (TW+1) x N per-channel count of 1s emitted; final when done
// BEHAVIOUR
//  Reset: state=IDLE; cnt, xs, xs_valid, done, busy = 0; ones[] = 0; latched regs = 0.
//  Run length: L = 2^min(len,TW). len=0 -> L=1. len>TW saturates to L=2^TW.
//  FSM IDLE -> RUN on start & !abort.
//   On that edge, latch Bxs/sel/rev/len, set cnt=0, clear ones[].
//  FSM RUN: each cycle with en=1, registers one sample with counter value k=cnt:
//   g_j = cnt[sel[j]*W +: W], bit-reversed if rev[j].
//   xs[j] <= (g_j < Bx_j) as unsigned W-bit compare; xs_valid <= 1; ones[j] += xs[j]-next.
//   Then cnt <= cnt+1.
//   en=0: cnt, ones, xs hold; xs_valid <= 0.
//   sel[j] >= S_GROUPS maps to group 0.
//  RUN -> DONE on the edge emitting sample k=L-1; cnt wraps to 0 for L=2^TW.
//  DONE (one cycle): done=1, xs_valid=0, then -> IDLE. ones[] hold until next accepted start.
//  Latency: first xs_valid is the cycle after start is accepted, if en=1 then.
//   Unstalled: L valid cycles, done on the cycle after the last valid.
//  abort in RUN or DONE: -> IDLE next edge.
//   No done pulse; xs_valid=0; ones[] hold partial counts; cnt=0.
//  abort in IDLE: no effect; abort with start in IDLE: abort wins, start dropped.
//  start while RUN/DONE: ignored (no queueing). Input changes after start do not affect the run.
//  Lowest group increments fastest. Channels on the same group with rev equal are maximally correlated.
//   Channels on different groups are uncorrelated over L=2^TW.
//  busy = (state==RUN). Reset asserted mid-run returns to reset values immediately.
// TESTING
//  W=4,S=2,N=2; ch0 Bx=8,sel=0,rev=0,len=4 -> xs0 = 1 x8 then 0 x8; ones0=8; done 17 cycles after start.
//  Same with rev=1 -> xs0 = 1,0,1,0,...; ones0=8. Early term len=2 -> 1,0,1,0; ones0=2; done after 4 samples.
//  ch0 Bx=4, ch1 Bx=12, both sel=0,rev=0,len=4 -> xs0 implies xs1 every sample; ones=4/12.
//  ch0 sel=0, ch1 sel=1, Bx=8 each, len=8 -> ones=128 each; count(xs0&xs1)=64.
//  en toggled 1,0 during len=3 run -> exactly 8 xs_valid pulses, same sequence as unstalled.
//   abort after 3 samples -> no done, ones partial, busy=0 next cycle.
//  start+abort in IDLE -> stays IDLE. len=15 saturates to 256 samples.
//   rst_n low mid-run -> all outputs 0 asynchronously; a new start works normally.

Source files
------------

// File: rtl/bpc_sng_et.sv
// Counter-based stochastic number generator: N channels share one TW-bit sample
// counter split into W-bit groups, with a programmable power-of-two run length.
module bpc_sng_et #(
  parameter int W        = 4,
  parameter int S_GROUPS = 2,
  parameter int N        = 2,
  parameter int GSW      = 1,
  parameter int LW       = 4,
  localparam int TW      = S_GROUPS * W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  en,
  input  logic [LW-1:0]         len,
  input  logic [N-1:0][W-1:0]   Bxs,
  input  logic [N-1:0][GSW-1:0] sel,
  input  logic [N-1:0]          rev,
  output logic                  busy,
  output logic [N-1:0]          xs,
  output logic                  xs_valid,
  output logic                  done,
  output logic [N-1:0][TW:0]    ones
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | emitting one sample per enabled cycle
  // DONE  | last sample emitted, done pulse issued on the next edge
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         cnt, last_k, last_k_nxt;
  logic [N-1:0][W-1:0]   bx_q;
  logic [N-1:0][GSW-1:0] sel_q;
  logic [N-1:0]          rev_q, smp;
  logic [LW-1:0]         len_eff;
  logic                  accept, fire, term;

  assign accept     = (state == IDLE) && start && !abort;
  assign fire       = (state == RUN) && en && !abort;
  assign term       = fire && (cnt == last_k);
  // len beyond TW saturates to a full counter sweep; shifting by TW yields all ones
  assign len_eff    = (len > LW'(TW)) ? LW'(TW) : len;
  assign last_k_nxt = ~({TW{1'b1}} << len_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (term) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic [W-1:0] g;
    logic [W-1:0] gr;
    int           gs;
    busy = (state == RUN);
    smp  = '0;
    g    = '0;
    gr   = '0;
    gs   = 0;
    for (int j = 0; j < N; j++) begin
      gs = (int'(sel_q[j]) < S_GROUPS) ? int'(sel_q[j]) : 0;
      g  = cnt[gs*W +: W];
      for (int i = 0; i < W; i++) gr[i] = g[W-1-i];
      smp[j] = (rev_q[j] ? gr : g) < bx_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      last_k   <= '0;
      bx_q     <= '0;
      sel_q    <= '0;
      rev_q    <= '0;
      xs       <= '0;
      xs_valid <= 1'b0;
      done     <= 1'b0;
      ones     <= '0;
    end else begin
      xs_valid <= 1'b0;
      done     <= (state == DONE) && !abort;
      unique case (state)
        IDLE: if (accept) begin
          bx_q   <= Bxs;
          sel_q  <= sel;
          rev_q  <= rev;
          last_k <= last_k_nxt;
          cnt    <= '0;
          ones   <= '0;
        end
        RUN: if (abort) begin
          cnt <= '0;
        end else if (fire) begin
          xs       <= smp;
          xs_valid <= 1'b1;
          cnt      <= cnt + TW'(1);
          for (int j = 0; j < N; j++) ones[j] <= ones[j] + (TW+1)'(smp[j]);
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bpc_sng_et.sv
// Bench for bpc_sng_et: sample-stream reference model checked every cycle, plus
// directed runs pinned to hand-computed sequences and counts.
module tb_bpc_sng_et;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            en = 1'b0;
  logic [3:0]      len = '0;
  logic [1:0][3:0] bxs = '0;
  logic [1:0][0:0] sel = '0;
  logic [1:0]      rev = '0;
  logic            busy;
  logic [1:0]      xs;
  logic            xs_valid;
  logic            done;
  logic [1:0][8:0] ones;

  bpc_sng_et #(.W(4), .S_GROUPS(2), .N(2), .GSW(1), .LW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .en(en), .len(len),
    .Bxs(bxs), .sel(sel), .rev(rev), .busy(busy), .xs(xs), .xs_valid(xs_valid),
    .done(done), .ones(ones)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // stochastic bit for sample index k: chosen 4-bit digit of k (optionally mirrored) below bx
  function automatic bit smp_model(input int k, input int bx, input int sl, input int rv);
    int g;
    int r;
    g = (k >> (4 * ((sl >= 2) ? 0 : sl))) & 15;
    r = 0;
    for (int i = 0; i < 4; i++) r |= ((g >> i) & 1) << (3 - i);
    return ((rv != 0) ? r : g) < bx;
  endfunction

  bit m_run = 0, m_fin = 0;
  int m_k = 0, m_L = 1;
  int m_bx[2] = '{0, 0};
  int m_sel[2] = '{0, 0};
  int m_rev[2] = '{0, 0};
  int exp_ones[2] = '{0, 0};
  bit [1:0] exp_xs = 0;
  bit exp_valid = 0, exp_done = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_fin = 0; m_k = 0; m_L = 1;
        exp_xs = 0; exp_valid = 0; exp_done = 0;
        exp_ones = '{0, 0};
      end else begin
        exp_valid = 0;
        exp_done = 0;
        if (m_fin) begin
          m_fin = 0;
          exp_done = !abort;
        end else if (m_run) begin
          if (abort) m_run = 0;
          else if (en) begin
            for (int j = 0; j < 2; j++) begin
              exp_xs[j] = smp_model(m_k, m_bx[j], m_sel[j], m_rev[j]);
              exp_ones[j] += int'(exp_xs[j]);
            end
            exp_valid = 1;
            m_k++;
            if (m_k == m_L) begin
              m_run = 0;
              m_fin = 1;
            end
          end
        end else if (start && !abort) begin
          for (int j = 0; j < 2; j++) begin
            m_bx[j] = int'(bxs[j]);
            m_sel[j] = int'(sel[j]);
            m_rev[j] = int'(rev[j]);
          end
          m_L = 1 << ((len > 8) ? 8 : int'(len));
          m_k = 0;
          exp_ones = '{0, 0};
          m_run = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("xs_valid", {63'd0, xs_valid}, {63'd0, exp_valid});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      chk("busy", {63'd0, busy}, {63'd0, m_run});
      chk("xs", {62'd0, xs}, {62'd0, exp_xs});
      chk("ones0", {55'd0, ones[0]}, 64'(exp_ones[0]));
      chk("ones1", {55'd0, ones[1]}, 64'(exp_ones[1]));
    end
  end

  logic [255:0] cap0, cap1;
  int nval, dcyc, both, impv;
  bit gotdone;

  task automatic do_run(input int bx0, input int bx1, input int sel0, input int sel1,
                        input int rev0, input int rev1, input int ln,
                        input int en_mode, input int abort_after);
    bit aborted;
    int abort_c;
    aborted = 0;
    abort_c = 0;
    @(negedge clk);
    bxs[0] = 4'(bx0); bxs[1] = 4'(bx1);
    sel[0] = 1'(sel0); sel[1] = 1'(sel1);
    rev[0] = 1'(rev0); rev[1] = 1'(rev1);
    len = 4'(ln);
    start = 1; abort = 0; en = 1;
    cap0 = '0; cap1 = '0;
    nval = 0; dcyc = 0; both = 0; impv = 0; gotdone = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = 0;
      abort = 0;
      bxs = 8'($urandom); sel = 2'($urandom); rev = 2'($urandom); len = 4'($urandom);
      if (xs_valid) begin
        if (nval < 256) begin
          cap0[nval] = xs[0];
          cap1[nval] = xs[1];
        end
        if (xs[0] && xs[1]) both++;
        if (xs[0] && !xs[1]) impv++;
        nval++;
      end
      if (done) begin
        gotdone = 1;
        dcyc = c - 1;
        break;
      end
      if (aborted && c >= abort_c + 2) break;
      if (abort_after >= 0 && !aborted && nval == abort_after) begin
        abort = 1;
        aborted = 1;
        abort_c = c;
      end
      case (en_mode)
        0: en = 1;
        1: en = ~en;
        default: begin
          en = ($urandom_range(0, 3) != 0);
          if (busy && $urandom_range(0, 7) == 0) start = 1;
        end
      endcase
    end
    if (!aborted) chk("run_bound", {63'd0, gotdone}, 64'd1);
    start = 0;
    abort = 0;
    en = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ones", {46'd0, ones}, 64'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    do_run(8, 0, 0, 0, 0, 0, 4, 0, -1);
    chk("t1_seq", {48'd0, cap0[15:0]}, 64'h00FF);
    chk("t1_ones0", {55'd0, ones[0]}, 64'd8);
    chk("t1_ones1", {55'd0, ones[1]}, 64'd0);
    chk("t1_done_cyc", 64'(dcyc), 64'd17);
    chk("t1_nval", 64'(nval), 64'd16);

    do_run(8, 0, 0, 0, 1, 0, 4, 0, -1);
    chk("t2_seq", {48'd0, cap0[15:0]}, 64'h5555);
    chk("t2_ones0", {55'd0, ones[0]}, 64'd8);

    do_run(8, 0, 0, 0, 1, 0, 2, 0, -1);
    chk("t3_seq", {60'd0, cap0[3:0]}, 64'h5);
    chk("t3_ones0", {55'd0, ones[0]}, 64'd2);
    chk("t3_nval", 64'(nval), 64'd4);
    chk("t3_done_cyc", 64'(dcyc), 64'd5);

    do_run(4, 12, 0, 0, 0, 0, 4, 0, -1);
    chk("t4_implication", 64'(impv), 64'd0);
    chk("t4_ones0", {55'd0, ones[0]}, 64'd4);
    chk("t4_ones1", {55'd0, ones[1]}, 64'd12);

    do_run(8, 8, 0, 1, 0, 0, 8, 0, -1);
    chk("t5_ones0", {55'd0, ones[0]}, 64'd128);
    chk("t5_ones1", {55'd0, ones[1]}, 64'd128);
    chk("t5_both", 64'(both), 64'd64);

    do_run(5, 0, 0, 0, 0, 0, 3, 1, -1);
    chk("t6_nval", 64'(nval), 64'd8);
    chk("t6_seq", {56'd0, cap0[7:0]}, 64'h1F);
    chk("t6_ones0", {55'd0, ones[0]}, 64'd5);

    do_run(8, 0, 0, 0, 0, 0, 4, 0, 3);
    chk("t7_no_done", {63'd0, gotdone}, 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd0);
    chk("t7_ones0", {55'd0, ones[0]}, 64'd3);

    @(negedge clk);
    start = 1; abort = 1; len = 4;
    @(negedge clk);
    start = 0; abort = 0;
    chk("t8_idle", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("t8_still_idle", {63'd0, busy}, 64'd0);

    do_run(3, 0, 1, 0, 0, 0, 15, 0, -1);
    chk("t9_nval", 64'(nval), 64'd256);
    chk("t9_ones0", {55'd0, ones[0]}, 64'd48);

    @(negedge clk);
    bxs[0] = 4'd8; sel = '0; rev = '0; len = 4'd4; start = 1; en = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_valid", {63'd0, xs_valid}, 64'd0);
    chk("arst_xs", {62'd0, xs}, 64'd0);
    chk("arst_ones", {46'd0, ones}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    en = 0;
    do_run(8, 0, 0, 0, 0, 0, 4, 0, -1);
    chk("t10_seq", {48'd0, cap0[15:0]}, 64'h00FF);
    chk("t10_ones0", {55'd0, ones[0]}, 64'd8);

    for (int r = 0; r < 24; r++) begin
      int ln;
      int ab;
      ln = ($urandom_range(0, 5) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ln, 2, ab);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
